// File: rtl/input_conditioner.sv
// Button and switch input conditioner: two-flop synchronizers, per-button debounce counters,
// press pulses with sticky pending flags and a masked interrupt, and tick-sampled switches.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES  = 500000,
    parameter int unsigned SW_SAMPLE_CYCLES = 1000000
) (
    input  logic        HCLK,
    input  logic        resetHW,
    input  logic [4:0]  btn_raw,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  irq_mask,
    input  logic [4:0]  pend_clr,
    output logic [4:0]  btn_clean,
    output logic [15:0] sw_clean,
    output logic [4:0]  btn_press,
    output logic [4:0]  btn_pend,
    output logic        btn_IRQ
);

    localparam logic [19:0] CntMax  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [20:0] TickMax = 21'(SW_SAMPLE_CYCLES - 1);

    logic [4:0]       btn_meta, btn_sync;
    logic [15:0]      sw_meta, sw_sync;
    logic [4:0][19:0] cnt_q, cnt_d;
    logic [4:0]       clean_d;
    logic [20:0]      tick_q, tick_d;
    logic             sample_tick;
    logic [15:0]      sw_prev;
    logic [15:0]      sw_agree, sw_clean_d;

    // Counter only advances while the synchronized level disagrees with the accepted one.
    always_comb begin
        cnt_d   = '0;
        clean_d = btn_clean;
        for (int i = 0; i < 5; i++) begin
            if (btn_sync[i] != btn_clean[i]) begin
                if (cnt_q[i] == CntMax) begin
                    clean_d[i] = btn_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    always_comb begin
        sample_tick = (tick_q == TickMax);
        tick_d      = sample_tick ? '0 : tick_q + 21'd1;
        // A switch bit is accepted only when two consecutive samples agree.
        sw_agree    = ~(sw_sync ^ sw_prev);
        sw_clean_d  = (sw_agree & sw_sync) | (~sw_agree & sw_clean);
    end

    always_ff @(posedge HCLK) begin
        if (resetHW) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            cnt_q     <= '0;
            tick_q    <= '0;
            sw_prev   <= '0;
            btn_clean <= '0;
            sw_clean  <= '0;
            btn_press <= '0;
            btn_pend  <= '0;
            btn_IRQ   <= 1'b0;
        end else begin
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
            sw_meta   <= sw_raw;
            sw_sync   <= sw_meta;
            cnt_q     <= cnt_d;
            btn_clean <= clean_d;
            btn_press <= clean_d & ~btn_clean;
            // Set has priority over clear so a press coinciding with a clear is not lost.
            btn_pend  <= (btn_pend & ~pend_clr) | btn_press;
            btn_IRQ   <= |(btn_pend & irq_mask);
            tick_q    <= tick_d;
            if (sample_tick) begin
                sw_prev  <= sw_sync;
                sw_clean <= sw_clean_d;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and SW_SAMPLE_CYCLES=8.
module tb_input_conditioner;

    logic        HCLK = 1'b0;
    logic        resetHW;
    logic [4:0]  btn_raw, irq_mask, pend_clr;
    logic [15:0] sw_raw;
    logic [4:0]  btn_clean, btn_press, btn_pend;
    logic [15:0] sw_clean;
    logic        btn_IRQ;

    int tests = 0;
    int fails = 0;
    int cyc;

    always #5 HCLK = ~HCLK;

    input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SW_SAMPLE_CYCLES(8)
    ) dut (
        .HCLK     (HCLK),
        .resetHW  (resetHW),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .irq_mask (irq_mask),
        .pend_clr (pend_clr),
        .btn_clean(btn_clean),
        .sw_clean (sw_clean),
        .btn_press(btn_press),
        .btn_pend (btn_pend),
        .btn_IRQ  (btn_IRQ)
    );

    // Edges since reset released; switch samples take effect on edges where cyc % 8 == 0.
    always @(posedge HCLK) begin
        if (resetHW) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] sw;
        logic [4:0]  mask;
        logic [4:0]  exp_clean;
        logic [15:0] exp_sw;
        logic [4:0]  exp_pend;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic align(input int ph);
        int guard = 0;
        while ((cyc % 8) != ph && guard < 16) begin
            tick();
            guard++;
        end
        if ((cyc % 8) != ph) begin
            fails++;
            $display("FAIL align: got phase %0d, want %0d", cyc % 8, ph);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_clean"}, 32'(btn_clean), 32'h0);
        chk({name, "_sw"},    32'(sw_clean),  32'h0);
        chk({name, "_press"}, 32'(btn_press), 32'h0);
        chk({name, "_pend"},  32'(btn_pend),  32'h0);
        chk({name, "_irq"},   32'(btn_IRQ),   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] seen;
        logic       sw_bad;

        //          btn       sw        mask      clean     sw_clean  pend      irq
        vecs[0] = '{5'b00000, 16'h0000, 5'b11111, 5'b00000, 16'h0000, 5'b00000, 1'b0};
        vecs[1] = '{5'b10101, 16'hA5A5, 5'b00001, 5'b10101, 16'hA5A5, 5'b10101, 1'b1};
        vecs[2] = '{5'b11010, 16'h5A5A, 5'b00101, 5'b11010, 16'h5A5A, 5'b01010, 1'b0};
        vecs[3] = '{5'b11111, 16'hFFFF, 5'b00100, 5'b11111, 16'hFFFF, 5'b00101, 1'b1};
        vecs[4] = '{5'b00000, 16'h0000, 5'b11111, 5'b00000, 16'h0000, 5'b00000, 1'b0};
        vecs[5] = '{5'b01000, 16'h1234, 5'b01000, 5'b01000, 16'h1234, 5'b01000, 1'b1};
        vecs[6] = '{5'b00000, 16'h00FF, 5'b00000, 5'b00000, 16'h00FF, 5'b00000, 1'b0};

        // Reset with all inputs active.
        resetHW  = 1'b1;
        btn_raw  = 5'b11111;
        sw_raw   = 16'hFFFF;
        irq_mask = 5'b11111;
        pend_clr = 5'b00000;
        tick();
        chk_all_zero("reset1");
        ticks(2);
        chk_all_zero("reset3");
        btn_raw = '0;
        sw_raw  = '0;
        resetHW = 1'b0;
        ticks(3);
        chk_all_zero("idle");

        // Press on button 1: raw captured at edge N, clean at N+5.
        btn_raw[1] = 1'b1;
        irq_mask   = 5'b00010;
        tick();
        ticks(4);
        chk("b1_clean_n4", 32'(btn_clean), 32'h0);
        tick();
        chk("b1_clean_n5", 32'(btn_clean), 32'h02);
        chk("b1_press_n5", 32'(btn_press), 32'h02);
        chk("b1_pend_n5",  32'(btn_pend),  32'h00);
        pend_clr = 5'b00010;
        tick();
        chk("b1_press_n6", 32'(btn_press), 32'h00);
        chk("b1_pend_set_wins", 32'(btn_pend), 32'h02);
        chk("b1_irq_n6", 32'(btn_IRQ), 32'h0);
        tick();
        chk("b1_pend_cleared", 32'(btn_pend), 32'h00);
        chk("b1_irq_n7", 32'(btn_IRQ), 32'h1);
        pend_clr = 5'b00000;
        tick();
        chk("b1_irq_n8", 32'(btn_IRQ), 32'h0);
        chk("b1_clean_held", 32'(btn_clean), 32'h02);

        // Three-cycle glitch on button 0 must be rejected.
        seen = '0;
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) btn_raw[0] = 1'b0;
            tick();
            seen |= {btn_clean[0], btn_press[0], btn_pend[0]};
        end
        chk("glitch_b0", 32'(seen), 32'h0);

        // Switches: steady value, then glitches clear of and across a sample tick.
        sw_raw = 16'hA5A5;
        ticks(26);
        chk("sw_a5a5", 32'(sw_clean), 32'hA5A5);
        align(0);
        sw_raw[3] = 1'b1;
        ticks(4);
        sw_raw[3] = 1'b0;
        sw_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sw_clean !== 16'hA5A5) sw_bad = 1'b1;
        end
        chk("sw_glitch_between", 32'(sw_bad), 32'h0);
        align(5);
        sw_raw[3] = 1'b1;
        ticks(4);
        sw_raw[3] = 1'b0;
        sw_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (sw_clean !== 16'hA5A5) sw_bad = 1'b1;
        end
        chk("sw_glitch_on_tick", 32'(sw_bad), 32'h0);

        // Table: clear pending, apply pattern, let everything settle, compare.
        for (int v = 0; v < 7; v++) begin
            pend_clr = 5'b11111;
            tick();
            pend_clr = 5'b00000;
            btn_raw  = vecs[v].btn;
            sw_raw   = vecs[v].sw;
            irq_mask = vecs[v].mask;
            ticks(40);
            chk($sformatf("vec%0d_clean", v), 32'(btn_clean), 32'(vecs[v].exp_clean));
            chk($sformatf("vec%0d_sw", v),    32'(sw_clean),  32'(vecs[v].exp_sw));
            chk($sformatf("vec%0d_pend", v),  32'(btn_pend),  32'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_irq", v),   32'(btn_IRQ),   32'(vecs[v].exp_irq));
        end

        // Reset in mid-debounce: partial counts must be discarded.
        btn_raw = 5'b11111;
        tick();
        ticks(2);
        resetHW = 1'b1;
        tick();
        chk_all_zero("midrst1");
        tick();
        chk_all_zero("midrst2");
        resetHW = 1'b0;
        tick();
        ticks(4);
        chk("rst_clean_e5", 32'(btn_clean), 32'h00);
        tick();
        chk("rst_clean_e6", 32'(btn_clean), 32'h1F);
        chk("rst_press_e6", 32'(btn_press), 32'h1F);
        tick();
        chk("rst_press_e7", 32'(btn_press), 32'h00);
        chk("rst_pend_e7",  32'(btn_pend),  32'h1F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
